// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: ALU path has priority, LSU results queue in an in-order FIFO.
// Optional macro WB_BYPASS_EN lets an LSU write skip the empty FIFO when the port is free.
module reg_wb_ctrl #(
  parameter int REG_SIZE   = 32,
  parameter int NO_OF_REGS = 32,
  parameter int REGW       = $clog2(NO_OF_REGS),
  parameter int DEPTH      = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      alu_valid_i,
  input  logic [REGW-1:0]           alu_rd_i,
  input  logic [REG_SIZE-1:0]       alu_data_i,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [REGW-1:0]           lsu_rd_i,
  input  logic [REG_SIZE-1:0]       lsu_data_i,
  input  logic                      issue_i,
  input  logic [REGW-1:0]           issue_rd_i,
  output logic                      we_o,
  output logic [REGW-1:0]           waddr_o,
  output logic [REG_SIZE-1:0]       wdata_o,
  output logic [NO_OF_REGS-1:0]     busy_o,
  output logic [$clog2(DEPTH):0]    fifo_cnt_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [REGW-1:0]       rd_mem   [DEPTH];
  logic [REG_SIZE-1:0]   data_mem [DEPTH];
  logic [PTRW-1:0]       wr_ptr_q;
  logic [PTRW-1:0]       rd_ptr_q;
  logic [CNTW-1:0]       cnt_q;
  logic [NO_OF_REGS-1:0] busy_q;
  logic [NO_OF_REGS-1:0] busy_next;
  logic [NO_OF_REGS-1:0] set_mask;
  logic [NO_OF_REGS-1:0] clr_mask;

  logic alu_win;
  logic lsu_live;
  logic fifo_empty;
  logic push;
  logic pop;
  logic bypass;

  assign lsu_ready_o = rst_ni && (cnt_q < CNTW'(DEPTH));
  assign alu_win     = alu_valid_i && (alu_rd_i != '0);
  assign lsu_live    = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
  assign fifo_empty  = (cnt_q == '0);
  assign pop         = !alu_win && !fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = !alu_win && fifo_empty && lsu_live;
`else
  assign bypass = 1'b0;
`endif

  assign push = lsu_live && !bypass;

  // Scoreboard: a new issue on the same edge as the retiring write keeps the bit set.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (pop) begin
      clr_mask[rd_mem[rd_ptr_q]] = 1'b1;
    end else if (bypass) begin
      clr_mask[lsu_rd_i] = 1'b1;
    end
    if (issue_i && (issue_rd_i != '0)) begin
      set_mask[issue_rd_i] = 1'b1;
    end
  end

  assign busy_next = (busy_q & ~clr_mask) | set_mask;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= {busy_next[NO_OF_REGS-1:1], 1'b0};
    end
  end

  // FIFO control; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= lsu_rd_i;
      data_mem[wr_ptr_q] <= lsu_data_i;
    end
  end

  // Output stage: ALU first, then FIFO head, then (optionally) bypassed LSU request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (alu_win) begin
      we_o    <= 1'b1;
      waddr_o <= alu_rd_i;
      wdata_o <= alu_data_i;
    end else if (pop) begin
      we_o    <= 1'b1;
      waddr_o <= rd_mem[rd_ptr_q];
      wdata_o <= data_mem[rd_ptr_q];
    end else if (bypass) begin
      we_o    <= 1'b1;
      waddr_o <= lsu_rd_i;
      wdata_o <= lsu_data_i;
    end else begin
      we_o    <= 1'b0;
    end
  end

  assign busy_o     = busy_q;
  assign fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Testbench for reg_wb_ctrl: queue-based reference model compared every cycle, plus directed literal checks.
module tb_reg_wb_ctrl;
  localparam int REG_SIZE   = 32;
  localparam int NO_OF_REGS = 32;
  localparam int REGW       = 5;
  localparam int DEPTH      = 4;
  localparam int CW         = 3;
`ifdef WB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  alu_valid_i = 1'b0;
  logic [REGW-1:0]       alu_rd_i = '0;
  logic [REG_SIZE-1:0]   alu_data_i = '0;
  logic                  lsu_valid_i = 1'b0;
  logic                  lsu_ready_o;
  logic [REGW-1:0]       lsu_rd_i = '0;
  logic [REG_SIZE-1:0]   lsu_data_i = '0;
  logic                  issue_i = 1'b0;
  logic [REGW-1:0]       issue_rd_i = '0;
  logic                  we_o;
  logic [REGW-1:0]       waddr_o;
  logic [REG_SIZE-1:0]   wdata_o;
  logic [NO_OF_REGS-1:0] busy_o;
  logic [CW-1:0]         fifo_cnt_o;

  reg_wb_ctrl #(.REG_SIZE(REG_SIZE), .NO_OF_REGS(NO_OF_REGS), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending LSU writes, a busy bit per register, the presented write.
  typedef struct packed {
    logic [REGW-1:0]     rd;
    logic [REG_SIZE-1:0] data;
  } wr_t;

  wr_t                   q[$];
  logic [NO_OF_REGS-1:0] m_busy = '0;
  logic                  m_we = 1'b0;
  logic [REGW-1:0]       m_waddr = '0;
  logic [REG_SIZE-1:0]   m_wdata = '0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      m_busy  = '0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      logic [NO_OF_REGS-1:0] clr;
      bit   accepted;
      bit   consumed;
      wr_t  h;
      clr      = '0;
      consumed = 0;
      accepted = lsu_valid_i && (q.size() < DEPTH) && (lsu_rd_i != 0);
      if (alu_valid_i && alu_rd_i != 0) begin
        m_we = 1'b1; m_waddr = alu_rd_i; m_wdata = alu_data_i;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        m_we = 1'b1; m_waddr = h.rd; m_wdata = h.data;
        clr[h.rd] = 1'b1;
      end
`ifdef WB_BYPASS_EN
      else if (accepted) begin
        m_we = 1'b1; m_waddr = lsu_rd_i; m_wdata = lsu_data_i;
        clr[lsu_rd_i] = 1'b1;
        consumed = 1;
      end
`endif
      else begin
        m_we = 1'b0;
      end
      if (accepted && !consumed) q.push_back('{rd: lsu_rd_i, data: lsu_data_i});
      m_busy = m_busy & ~clr;
      if (issue_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
      m_busy[0] = 1'b0;
    end
  end

  always @(negedge clk_i) begin
    chk("model_we", we_o, m_we);
    chk("model_waddr", waddr_o, m_waddr);
    chk("model_wdata", wdata_o, m_wdata);
    chk("model_busy", busy_o, m_busy);
    chk("model_cnt", fifo_cnt_o, q.size());
    chk("model_ready", lsu_ready_o, rst_ni && (q.size() < DEPTH));
  end

  task automatic idle();
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    issue_i     = 1'b0;
  endtask

  initial begin
    int k;
    int lat;
    bit acc;
    bit done;
    int seen_rd[$];
    logic [REG_SIZE-1:0] seen_data[$];
    logic [REGW-1:0] mrd;

    // 1. reset held for 3 cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("rst_we", we_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_cnt", fifo_cnt_o, 0);
      chk("rst_ready", lsu_ready_o, 0);
    end
    #1 rst_ni = 1'b1;
    #1 chk("ready_after_release", lsu_ready_o, 1);

    // 2. ALU only
    @(negedge clk_i);
    alu_valid_i = 1'b1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("alu_we", we_o, 1);
    chk("alu_waddr", waddr_o, 5);
    chk("alu_wdata", wdata_o, 32'hDEADBEEF);
    alu_rd_i = 0; alu_data_i = 32'h1;
    @(negedge clk_i);
    chk("alu_rd0_we", we_o, 0);
    chk("alu_rd0_hold_addr", waddr_o, 5);
    idle();

    // 3. ALU priority while the LSU fills the FIFO
    k = 1;
    for (int c = 0; c < 16; c++) begin
      alu_valid_i = (c < 6); alu_rd_i = 20; alu_data_i = c;
      lsu_valid_i = (k <= 5); lsu_rd_i = REGW'(k); lsu_data_i = 32'h11 * k;
      acc = lsu_valid_i && lsu_ready_o;
      @(negedge clk_i);
      if (acc) k++;
      if (c == 5) begin
        chk("prio_cnt_full", fifo_cnt_o, 4);
        chk("prio_ready_low", lsu_ready_o, 0);
        chk("prio_accepts", k - 1, 4);
      end
      if (c >= 6 && we_o) begin
        seen_rd.push_back(int'(waddr_o));
        seen_data.push_back(wdata_o);
      end
    end
    idle();
    chk("prio_nwrites", seen_rd.size(), 5);
    for (int i = 0; i < seen_rd.size(); i++) begin
      chk("prio_order_rd", seen_rd[i], i + 1);
      chk("prio_order_data", seen_data[i], 32'h11 * (i + 1));
    end

    // 4a. scoreboard set then cleared by the retiring load
    issue_i = 1'b1; issue_rd_i = 7;
    @(negedge clk_i);
    issue_i = 1'b0;
    chk("sb_busy_set", busy_o[7], 1);
    lsu_valid_i = 1'b1; lsu_rd_i = 7; lsu_data_i = 32'hA5;
    done = 0; lat = 0;
    while (!done && lat < 5) begin
      @(negedge clk_i);
      lsu_valid_i = 1'b0;
      lat++;
      if (we_o && waddr_o == 7) done = 1;
      else chk("sb_busy_hold", busy_o[7], 1);
    end
    chk("sb_write_seen", done, 1);
    chk("sb_latency", lat, EXP_LAT);
    chk("sb_wdata", wdata_o, 32'hA5);
    chk("sb_busy_clear", busy_o[7], 0);

    // 4b. re-issue on the retiring edge keeps the bit set
    issue_i = 1'b1; issue_rd_i = 7;
    @(negedge clk_i);
    issue_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 7; lsu_data_i = 32'hA6;
    for (int e = 1; e <= EXP_LAT; e++) begin
      issue_i = (e == EXP_LAT); issue_rd_i = 7;
      @(negedge clk_i);
      lsu_valid_i = 1'b0;
    end
    issue_i = 1'b0;
    chk("sb_reissue_we", we_o, 1);
    chk("sb_reissue_addr", waddr_o, 7);
    chk("sb_reissue_busy", busy_o[7], 1);
    @(negedge clk_i);

    // 5. LSU latency with empty FIFO and idle ALU
    lsu_valid_i = 1'b1; lsu_rd_i = 9; lsu_data_i = 32'h1234;
    lat = 0;
    do begin
      @(negedge clk_i);
      lsu_valid_i = 1'b0;
      lat++;
    end while (!we_o && lat < 5);
    chk("byp_latency", lat, EXP_LAT);
    chk("byp_waddr", waddr_o, 9);
    chk("byp_wdata", wdata_o, 32'h1234);
    @(negedge clk_i);

    // 6. mid-operation asynchronous reset
    for (int c = 0; c < 3; c++) begin
      mrd = (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : 5'd7;
      alu_valid_i = 1'b1; alu_rd_i = 20; alu_data_i = 32'hC0DE + c;
      lsu_valid_i = 1'b1; lsu_rd_i = mrd; lsu_data_i = 32'hBEE0 + c;
      issue_i = 1'b1; issue_rd_i = mrd;
      @(negedge clk_i);
    end
    lsu_valid_i = 1'b0; issue_i = 1'b0;
    chk("mid_cnt3", fifo_cnt_o, 3);
    chk("mid_busy", busy_o, 32'h0000_0086);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_we", we_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cnt", fifo_cnt_o, 0);
    chk("mid_rst_ready", lsu_ready_o, 0);
    idle();
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("mid_no_stale_we", we_o, 0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      alu_valid_i = ($urandom_range(0, 9) < 4);
      alu_rd_i    = ($urandom_range(0, 3) == 0) ? 5'd0 : REGW'($urandom_range(1, 31));
      alu_data_i  = $urandom;
      lsu_valid_i = ($urandom_range(0, 1) == 1);
      lsu_rd_i    = ($urandom_range(0, 5) == 0) ? 5'd0 : REGW'($urandom_range(1, 31));
      lsu_data_i  = $urandom;
      issue_i     = ($urandom_range(0, 9) < 3);
      issue_rd_i  = REGW'($urandom_range(0, 31));
      if (c == 700) begin
        #2 rst_ni = 1'b0;
        #3 rst_ni = 1'b1;
      end
      @(negedge clk_i);
    end
    idle();
    repeat (10) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
